// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding buffer so frames can go out back-to-back.
// tx is registered; every bit, including start and stop, lasts exactly CLK_FREQ/BAUD_RATE clocks.
module uart_transmitter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic                  r_tx;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_shift_sr;
    logic                  w_tx_nxt;
    logic                  w_load;
    logic                  w_bit_end;
    logic                  w_accept;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_accept   = data_valid & ~r_buf_full;
    assign w_shift_sr = r_shift >> 1;

    assign data_ready = ~r_buf_full;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) | r_buf_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            // load and accept are exclusive: one needs the buffer full, the other empty
            if (w_load) begin
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf      <= data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_shift_nxt = r_buf;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = w_shift_sr;
                        w_idx_nxt   = r_idx + 1'b1;
                        w_tx_nxt    = w_shift_sr[0];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // a queued byte chains straight into the next start bit
                    if (r_buf_full) begin
                        w_load      = 1'b1;
                        w_shift_nxt = r_buf;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at BIT_CYCLES=10: a schedule-level line model predicts tx/busy/data_ready every cycle.
module tb_uart_transmitter;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DW        = 8;
    localparam int BITC      = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = (DW + 2) * BITC;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          tx;
    logic          busy;

    uart_transmitter #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            s;
        logic [DW-1:0] b;
    } frame_t;

    frame_t        frames[$];
    int            cyc = 0;
    int            line_free = 0;
    logic          m_buf_has = 1'b0;
    int            m_buf_start = 0;
    logic          req_pending = 1'b0;
    logic [DW-1:0] req_byte = '0;
    int            nvec = 0;
    int            nerr = 0;

    // One clock: drive, advance the model at the edge, compare half a cycle later.
    // A byte accepted at edge n starts its frame at max(n+1, end of the previous frame).
    task automatic step(input logic rst_val);
        logic acc;
        int   n, s, j;
        logic etx, ebusy, erdy;
        rst        = rst_val;
        data_valid = req_pending;
        data       = req_byte;
        acc = req_pending && rst_val && !m_buf_has;
        @(posedge clk);
        cyc++;
        n = cyc;
        if (!rst_val) begin
            frames.delete();
            m_buf_has = 1'b0;
            line_free = n;
        end else begin
            if (m_buf_has && n >= m_buf_start) m_buf_has = 1'b0;
            if (acc) begin
                s = (n + 1 > line_free) ? n + 1 : line_free;
                frames.push_back('{s: s, b: req_byte});
                if (frames.size() > 4) void'(frames.pop_front());
                line_free   = s + FRAME;
                m_buf_has   = 1'b1;
                m_buf_start = s;
                req_pending = 1'b0;
            end
        end
        @(negedge clk);
        etx   = 1'b1;
        ebusy = m_buf_has;
        erdy  = !m_buf_has;
        foreach (frames[i]) begin
            if (n >= frames[i].s && n < frames[i].s + FRAME) begin
                j     = (n - frames[i].s) / BITC;
                ebusy = 1'b1;
                if (j == 0) etx = 1'b0;
                else if (j <= DW) etx = frames[i].b[j-1];
                else etx = 1'b1;
            end
        end
        nvec += 3;
        if (tx !== etx) begin
            nerr++;
            if (nerr < 40) $display("FAIL tx cyc=%0d got=%b exp=%b", n, tx, etx);
        end
        if (busy !== ebusy) begin
            nerr++;
            if (nerr < 40) $display("FAIL busy cyc=%0d got=%b exp=%b", n, busy, ebusy);
        end
        if (data_ready !== erdy) begin
            nerr++;
            if (nerr < 40) $display("FAIL data_ready cyc=%0d got=%b exp=%b", n, data_ready, erdy);
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(1'b1);
    endtask

    task automatic send(input logic [DW-1:0] b);
        req_pending = 1'b1;
        req_byte    = b;
    endtask

    task automatic wait_accept(input int limit);
        int k = 0;
        while (req_pending && k < limit) begin
            step(1'b1);
            k++;
        end
        nvec++;
        if (req_pending) begin
            nerr++;
            $display("FAIL accept_timeout cyc=%0d got=pending exp=accepted", cyc);
            req_pending = 1'b0;
        end
    endtask

    task automatic test_reset();
        send(8'hC3);            // handshake offered during reset must be discarded
        for (int i = 0; i < 3; i++) step(1'b0);
        req_pending = 1'b0;
        run(5);
    endtask

    task automatic test_single();
        send(8'h55);
        run(FRAME + 10);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        a = 8'hA5;
        b = 8'h3C;
        send(a);
        run(1 + $urandom_range(1, 80));
        send(b);
        run(2 * FRAME + 10);
        a = DW'($urandom);
        b = DW'($urandom);
        send(a);
        run(1 + $urandom_range(1, FRAME - 1));
        send(b);
        run(2 * FRAME + 10);
    endtask

    task automatic test_backpressure();
        send(DW'($urandom));
        run(2);
        send(DW'($urandom));
        run(1);
        send(DW'($urandom));    // held against a full buffer until it drains
        run(3 * FRAME + 10);
    endtask

    task automatic test_reset_mid();
        send(8'hFF);
        run(2);
        send(DW'($urandom));
        run(1 + 4 * BITC + 2);  // inside data bit 3
        step(1'b0);
        run(3 * FRAME);
    endtask

    task automatic test_simultaneous();
        send(8'h00);
        run(FRAME + 1);         // edges E0 .. E0+FRAME
        send(8'h81);            // accepted on the STOP-ending edge
        run(FRAME + 20);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            send(DW'($urandom));
            wait_accept(3 * FRAME);
            run($urandom_range(0, FRAME + 20));
        end
        run(2 * FRAME + 5);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serializes parallel bytes onto a UART line: 8N1 framing (1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit), idle-high. It is the transmit half of the team's UART link and pairs with the existing receiver on the same 50 MHz fabric clock. A one-entry holding buffer lets the producer queue the next byte while the current frame is on the wire, so frames can be sent back-to-back with no gap.

## Interface
- CLK_FREQ, 50_000_000, fabric clock frequency in Hz
- BAUD_RATE, 9600, line rate in bits/s
- DATA_WIDTH, 8, data bits per frame
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- data  input  DATA_WIDTH  byte to send, sampled on handshake
- data_valid  input  1  producer has a byte on `data`
- data_ready  output  1  holding buffer empty, byte will be accepted
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress or byte buffered

## Operation
- BIT_CYCLES = CLK_FREQ / BAUD_RATE (integer division; 5208 at defaults). Baud counter width $clog2(BIT_CYCLES), counts 0..BIT_CYCLES-1.
- Handshake: byte accepted on a rising edge where data_valid = 1 and data_ready = 1. data_ready = !buf_full (combinational from flag). data_valid with data_ready = 0 is ignored; producer holds data stable until accepted.
- Holding buffer: DATA_WIDTH register plus buf_full flag. Set on accept; cleared when its contents move to the shift register.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If buf_full: shift reg <= buffer, buf_full <= 0, counter <= 0, -> START.
  - START: tx = 0 for BIT_CYCLES cycles, then bit index <= 0, -> DATA.
  - DATA: tx = shift_reg[0]; every BIT_CYCLES cycles shift right by one, bit index +1; after DATA_WIDTH bits -> STOP.
  - STOP: tx = 1 for BIT_CYCLES cycles. At end: if buf_full (value before this edge) load shifter, clear buf_full, -> START directly; else -> IDLE.
- tx is a registered output; every bit occupies exactly BIT_CYCLES cycles; frame = (DATA_WIDTH+2)*BIT_CYCLES cycles.
- busy = (state != IDLE) | buf_full.
- Buffer may be filled in any state, including during START/DATA/STOP of the current frame.

## Timing
- Reset (rst = 0 at an edge): state <= IDLE, tx <= 1, buf_full <= 0, counter <= 0, shift reg <= 0. After that edge: tx = 1, busy = 0, data_ready = 1. Handshakes at an edge with rst = 0 are discarded.
- Reset mid-frame: frame aborted, tx high at the next edge, buffered byte dropped.
- Latency from idle: accept at edge E0 -> buf_full = 1 (data_ready = 0) after E0; edge E0+1 loads shifter, tx falls to 0, data_ready returns to 1.
- Start bit spans edges E0+1 .. E0+1+BIT_CYCLES; data bit k starts at E0+1+(k+1)*BIT_CYCLES; stop bit ends (IDLE or next START) at E0+1+(DATA_WIDTH+2)*BIT_CYCLES.
- Back-to-back: byte accepted any time before the final STOP edge -> next start bit begins on that edge, zero idle cycles between frames.
- Simultaneous: accept on the same edge that ends STOP with buffer empty -> FSM goes to IDLE, byte buffered, start bit one cycle later (1-cycle high gap).
- Only one byte may be queued; data_ready stays 0 until the buffered byte enters the shifter.

## Test plan
- Single byte, CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CYCLES=10): send 0x55 -> tx falls 1 cycle after accept; line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each exactly 10 cycles; busy drops after 100 cycles.
- Back-to-back: accept 0xA5, then 0x3C during first frame -> data_ready low until 0xA5 loads, low again after 0x3C accepted; 0x3C start bit immediately follows 0xA5 stop bit, 200 contiguous frame cycles.
- Backpressure: hold data_valid=1 with a new byte while buffer is full -> data unchanged on line, byte accepted only on the edge data_ready returns to 1, no duplicate or lost byte.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0xFF with a byte buffered -> tx=1, busy=0, data_ready=1 after the reset edge; no further frames emitted.
- Simultaneous edge: accept 0x81 on the exact STOP-ending edge of 0x00 -> exactly one cycle of tx=1 gap, then correct 0x81 frame.
- Default params loopback into the team's UART receiver: 256 random bytes -> all received in order, bit period 5208 cycles.
